// File: rtl/gate_pulse_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_pulse_meter: measures trigger-to-pulse delay and pulse width (cycles). |
// | Optional macro GPM_TIMEOUT_EN aborts a stalled measurement after TIMEOUT.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module gate_pulse_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_trigger,
  input  logic             i_pulse,
  output logic [CNT_W-1:0] o_delay,
  output logic [CNT_W-1:0] o_width,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_IN   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
`ifdef GPM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  // A TIMEOUT beyond the counter range can never be reached, so it disables itself.
  localparam bit TMO_ACT = TMO_EN && ((64'(TIMEOUT) >> CNT_W) == 64'd0);

  logic [1:0]       state_q, state_d;
  logic             trig_meta_q, trig_meta_d, trig_sync_q, trig_sync_d, trig_last_q, trig_last_d;
  logic             pulse_meta_q, pulse_meta_d, pulse_sync_q, pulse_sync_d, pulse_last_q, pulse_last_d;
  logic [CNT_W-1:0] delay_q, delay_d, width_q, width_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d;
  logic [CNT_W-1:0] out_delay_q, out_delay_d, out_width_q, out_width_d;
  logic             out_valid_q, out_valid_d, out_ovf_q, out_ovf_d, out_tmo_q, out_tmo_d;

  logic             trig_rise, pulse_rise, pulse_fall;
  logic             delay_at_max, width_at_max;
  logic [CNT_W-1:0] delay_inc, width_inc;

  assign trig_rise    = trig_sync_q & ~trig_last_q;
  assign pulse_rise   = pulse_sync_q & ~pulse_last_q;
  assign pulse_fall   = ~pulse_sync_q & pulse_last_q;
  assign delay_at_max = (delay_q == CNT_MAX);
  assign width_at_max = (width_q == CNT_MAX);
  assign delay_inc    = delay_at_max ? delay_q : delay_q + CNT_W'(1);
  assign width_inc    = width_at_max ? width_q : width_q + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      trig_meta_q  <= 1'b0;
      trig_sync_q  <= 1'b0;
      trig_last_q  <= 1'b0;
      pulse_meta_q <= 1'b0;
      pulse_sync_q <= 1'b0;
      pulse_last_q <= 1'b0;
      delay_q      <= '0;
      width_q      <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      out_delay_q  <= '0;
      out_width_q  <= '0;
      out_valid_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_meta_q  <= trig_meta_d;
      trig_sync_q  <= trig_sync_d;
      trig_last_q  <= trig_last_d;
      pulse_meta_q <= pulse_meta_d;
      pulse_sync_q <= pulse_sync_d;
      pulse_last_q <= pulse_last_d;
      delay_q      <= delay_d;
      width_q      <= width_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      out_delay_q  <= out_delay_d;
      out_width_q  <= out_width_d;
      out_valid_q  <= out_valid_d;
      out_ovf_q    <= out_ovf_d;
      out_tmo_q    <= out_tmo_d;
    end
  end

  // Next state and measurement counters; the delay counter doubles as the latched delay result.
  always_comb begin
    trig_meta_d  = i_trigger;
    trig_sync_d  = trig_meta_q;
    trig_last_d  = trig_sync_q;
    pulse_meta_d = i_pulse;
    pulse_sync_d = pulse_meta_q;
    pulse_last_d = pulse_sync_q;
    state_d      = state_q;
    delay_d      = delay_q;
    width_d      = width_q;
    ovf_d        = ovf_q;
    tmo_d        = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          delay_d = '0;
          width_d = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = pulse_rise ? S_IN : S_WAIT;
        end
      end
      S_WAIT: begin
        delay_d = delay_inc;
        ovf_d   = ovf_q | delay_at_max;
        if (pulse_rise) begin
          state_d = S_IN;
        end else if (TMO_ACT && (delay_inc == C_TIMEOUT)) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      S_IN: begin
        width_d = width_inc;
        ovf_d   = ovf_q | width_at_max;
        if (pulse_fall) begin
          state_d = S_DONE;
        end else if (TMO_ACT && (width_inc == C_TIMEOUT)) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != S_IDLE);
    out_valid_d = (state_q == S_DONE);
    out_delay_d = out_valid_d ? delay_q : out_delay_q;
    out_width_d = out_valid_d ? width_q : out_width_q;
    out_ovf_d   = out_valid_d ? ovf_q   : out_ovf_q;
    out_tmo_d   = out_valid_d ? tmo_q   : out_tmo_q;
  end

  assign o_delay   = out_delay_q;
  assign o_width   = out_width_q;
  assign o_valid   = out_valid_q;
  assign o_ovf     = out_ovf_q;
  assign o_timeout = out_tmo_q;

endmodule
`default_nettype wire
